// File: rtl/data_mem_responder.sv
// Data-side RAM responder: zero-fill sweep after reset, then combinational reads and byte-enabled writes.
// Read latency 0, write commits on the edge, trace is registered one cycle later; never stalls the core.
module data_mem_responder #(
  parameter int ADDR_WORDS = 3072,
  parameter int AW         = 12
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [31:0] m_data_addr,
  input  logic [31:0] m_data_wdata,
  input  logic [3:0]  m_data_byteen,
  input  logic [31:0] m_inst_addr,
  output logic [31:0] m_data_rdata,
  output logic        init_done,
  output logic        trace_valid,
  output logic [31:0] trace_pc,
  output logic [31:0] trace_addr,
  output logic [31:0] trace_data,
  output logic        err_oob,
  output logic [31:0] err_addr
);

  localparam logic [32:0]   LIMIT    = 33'(ADDR_WORDS) * 33'd4;
  localparam logic [AW-1:0] LAST_IDX = AW'(ADDR_WORDS - 1);

  typedef enum logic {S_CLEAR, S_READY} state_e;

  state_e        state_q;
  logic [AW-1:0] clr_idx_q;
  logic          init_done_q;
  logic          trace_valid_q;
  logic [31:0]   trace_pc_q;
  logic [31:0]   trace_addr_q;
  logic [31:0]   trace_data_q;
  logic          err_oob_q;
  logic [31:0]   err_addr_q;

  logic [31:0]   mem [ADDR_WORDS];

  logic [AW-1:0] idx;
  logic          in_range;
  logic          ready;
  logic          wr_en;
  logic [31:0]   old_word;
  logic [31:0]   merged_d;

  assign idx      = m_data_addr[AW+1:2];
  assign in_range = ({1'b0, m_data_addr} < LIMIT);
  assign ready    = (state_q == S_READY);
  assign wr_en    = ready && in_range && (m_data_byteen != 4'b0000);
  assign old_word = mem[idx];

  always_comb begin
    merged_d = old_word;
    for (int i = 0; i < 4; i++) begin
      if (m_data_byteen[i]) merged_d[8*i +: 8] = m_data_wdata[8*i +: 8];
    end
  end

  // idx is only trusted when in_range; out-of-range reads must return 0, not an aliased word
  assign m_data_rdata = (ready && in_range) ? old_word : 32'h0;

  // Gating with reset keeps a store that coincides with reset assertion out of the RAM
  always_ff @(posedge clk) begin
    if (state_q == S_CLEAR) begin
      mem[clr_idx_q] <= 32'h0;
    end else if (reset && wr_en) begin
      mem[idx] <= merged_d;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q       <= S_CLEAR;
      clr_idx_q     <= '0;
      init_done_q   <= 1'b0;
      trace_valid_q <= 1'b0;
      trace_pc_q    <= 32'h0;
      trace_addr_q  <= 32'h0;
      trace_data_q  <= 32'h0;
      err_oob_q     <= 1'b0;
      err_addr_q    <= 32'h0;
    end else begin
      case (state_q)
        S_CLEAR: begin
          trace_valid_q <= 1'b0;
          clr_idx_q     <= clr_idx_q + 1'b1;
          if (clr_idx_q == LAST_IDX) begin
            state_q     <= S_READY;
            init_done_q <= 1'b1;
          end
        end
        S_READY: begin
          trace_valid_q <= wr_en;
          if (wr_en) begin
            trace_pc_q   <= m_inst_addr;
            trace_addr_q <= {m_data_addr[31:2], 2'b00};
            trace_data_q <= merged_d;
          end
          if (!in_range) begin
            if (!err_oob_q) err_addr_q <= m_data_addr;
            err_oob_q <= 1'b1;
          end
        end
        default: state_q <= S_CLEAR;
      endcase
    end
  end

  assign init_done   = init_done_q;
  assign trace_valid = trace_valid_q;
  assign trace_pc    = trace_pc_q;
  assign trace_addr  = trace_addr_q;
  assign trace_data  = trace_data_q;
  assign err_oob     = err_oob_q;
  assign err_addr    = err_addr_q;

endmodule
